// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy formation: position field layout,
// the empty-position marker, move-phase encodings and scheduler states.
package enemy_pkg;

    // Packed enemy position: horizontal in [18:9], vertical in [8:0].
    localparam int HPOS_W   = 10;
    localparam int VPOS_W   = 9;
    localparam int POS_W    = HPOS_W + VPOS_W;
    localparam int HPOS_MSB = 18;
    localparam int HPOS_LSB = 9;

    // Marker for "no enemy here".
    localparam logic [POS_W-1:0] NONE = 19'h7FFFF;

    // Move phase shared by every row. The two left phases (00, 11) have
    // equal bits; the two right phases (01, 10) have differing bits.
    localparam logic [1:0] PH_LEFT_A  = 2'b00;
    localparam logic [1:0] PH_RIGHT_A = 2'b01;
    localparam logic [1:0] PH_RIGHT_B = 2'b10;
    localparam logic [1:0] PH_LEFT_B  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        UPDATE,
        ADVANCE
    } sched_state_e;

    // True when the formation is moving left in this phase.
    function automatic logic phase_is_left(input logic [1:0] phase);
        return phase[1] == phase[0];
    endfunction

endpackage

// File: rtl/enemy_step_timer.sv
// Frame-tick divider: counts qualified frame ticks and flags the tick
// that completes a march step. The counter clears itself on that tick.
module enemy_step_timer
    import enemy_pkg::*;
#(
    parameter int STEP_PERIOD = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic tick_i,
    output logic step_due_o
);

    localparam int CW = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_PERIOD - 1);

    logic [CW-1:0] count_q, count_d;

    assign step_due_o = tick_i && (count_q == LAST);

    // Next count: clear wins, then wrap on the step tick, else count ticks.
    always_comb begin
        // NOTE: default assignment first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (clear_i || step_due_o) begin
            count_d = '0;
        end else if (tick_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/enemy_march_scheduler.sv
// Enemy march scheduler: divides frame ticks into march steps, strobes one
// row per clock during a step, then advances the shared move phase when the
// formation reaches an edge or a sweep runs out of steps.
module enemy_march_scheduler
    import enemy_pkg::*;
#(
    parameter int          ROW_COUNT   = 3,
    parameter int          STEP_PERIOD = 4,
    parameter int          SWEEP_STEPS = 64,
    parameter logic [9:0]  LEFT_BOUND  = 10'd16,
    parameter logic [9:0]  RIGHT_BOUND = 10'd608
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_FrameTick,
    input  logic                 i_Enable,
    input  logic [ROW_COUNT-1:0] i_AliveMask,
    input  logic [HPOS_W-1:0]    i_MinX,
    input  logic [HPOS_W-1:0]    i_MaxX,
    output logic [1:0]           o_PhaseState,
    output logic [ROW_COUNT-1:0] o_RowUpdate,
    output logic                 o_Busy
);

    localparam int RW = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1;
    localparam int SW = (SWEEP_STEPS > 1) ? $clog2(SWEEP_STEPS) : 1;
    localparam logic [RW-1:0] LAST_ROW  = RW'(ROW_COUNT - 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(SWEEP_STEPS - 1);

    sched_state_e         state_q, state_d;
    logic [RW-1:0]        row_idx_q, row_idx_d;
    logic [SW-1:0]        step_q, step_d;
    logic [1:0]           phase_q, phase_d;
    logic [ROW_COUNT-1:0] row_update_q, row_update_d;
    logic                 busy_q, busy_d;

    logic timer_tick;
    logic timer_clear;
    logic step_due;
    logic hit;

    // Ticks only count while waiting, enabled and with something left alive;
    // a disable in WAIT wins over a simultaneous tick and restarts the count.
    assign timer_tick  = (state_q == WAIT) && i_Enable && i_FrameTick && (|i_AliveMask);
    assign timer_clear = (state_q == WAIT) && !i_Enable;

    enemy_step_timer #(
        .STEP_PERIOD (STEP_PERIOD)
    ) u_step_timer (
        .clk_i      (i_Clk),
        .rst_i      (i_Rst),
        .clear_i    (timer_clear),
        .tick_i     (timer_tick),
        .step_due_o (step_due)
    );

    // Next-state logic; outputs are computed from the next state so they register as Moore outputs.
    always_comb begin
        state_d      = state_q;
        row_idx_d    = row_idx_q;
        step_d       = step_q;
        phase_d      = phase_q;
        row_update_d = '0;
        busy_d       = 1'b0;
        hit          = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_Enable) state_d = WAIT;
            end
            WAIT: begin
                if (!i_Enable) begin
                    state_d = IDLE;
                end else if (step_due) begin
                    state_d   = UPDATE;
                    row_idx_d = '0;
                end
            end
            UPDATE: begin
                // The scan always completes so every row moves in the same step.
                if (row_idx_q == LAST_ROW) begin
                    state_d = ADVANCE;
                end else begin
                    row_idx_d = row_idx_q + 1'b1;
                end
            end
            ADVANCE: begin
                hit = phase_is_left(phase_q) ? (i_MinX <= LEFT_BOUND)
                                             : (i_MaxX >= RIGHT_BOUND);
                if (hit || (step_q == LAST_STEP)) begin
                    phase_d = phase_q + 2'd1;
                    step_d  = '0;
                end else begin
                    step_d  = step_q + 1'b1;
                end
                state_d = i_Enable ? WAIT : IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == UPDATE) || (state_d == ADVANCE);
        if ((state_d == UPDATE) && i_AliveMask[row_idx_d]) begin
            row_update_d = ROW_COUNT'(1) << row_idx_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q      <= IDLE;
            row_idx_q    <= '0;
            step_q       <= '0;
            phase_q      <= PH_LEFT_A;
            row_update_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_idx_q    <= row_idx_d;
            step_q       <= step_d;
            phase_q      <= phase_d;
            row_update_q <= row_update_d;
            busy_q       <= busy_d;
        end
    end

    assign o_PhaseState = phase_q;
    assign o_RowUpdate  = row_update_q;
    assign o_Busy       = busy_q;

endmodule

// File: tb/tb_enemy_march_scheduler.sv
// Directed bench for enemy_march_scheduler with ROW_COUNT=3, STEP_PERIOD=2,
// SWEEP_STEPS=4. Inputs change 1ns after a rising edge; outputs are sampled there.
module tb_enemy_march_scheduler;
    import enemy_pkg::*;

    localparam logic [9:0] MID_MIN = 10'd300;
    localparam logic [9:0] MID_MAX = 10'd320;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       enable;
    logic [2:0] alive;
    logic [9:0] min_x;
    logic [9:0] max_x;
    logic [1:0] phase_o;
    logic [2:0] row_o;
    logic       busy_o;

    int         tests = 0;
    int         fails = 0;
    logic [1:0] exp_phase;

    always #5 clk = ~clk;

    enemy_march_scheduler #(
        .ROW_COUNT   (3),
        .STEP_PERIOD (2),
        .SWEEP_STEPS (4),
        .LEFT_BOUND  (10'd16),
        .RIGHT_BOUND (10'd608)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_FrameTick  (frame_tick),
        .i_Enable     (enable),
        .i_AliveMask  (alive),
        .i_MinX       (min_x),
        .i_MaxX       (max_x),
        .o_PhaseState (phase_o),
        .o_RowUpdate  (row_o),
        .o_Busy       (busy_o)
    );

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        clk_step();
        frame_tick = 1'b0;
    endtask

    // One full march step from WAIT with the frame counter at 0.
    task automatic run_step(input string tag, input logic [2:0] s0, input logic [2:0] s1,
                            input logic [2:0] s2, input logic [9:0] adv_min,
                            input logic [9:0] adv_max, input logic [1:0] phase_after);
        pulse_tick();
        clk_step();
        check({tag, "_wait_busy"}, 32'(busy_o), 32'd0);
        pulse_tick();
        check({tag, "_row0"}, 32'(row_o), 32'(s0));
        check({tag, "_busy0"}, 32'(busy_o), 32'd1);
        check({tag, "_phase_scan"}, 32'(phase_o), 32'(exp_phase));
        clk_step();
        check({tag, "_row1"}, 32'(row_o), 32'(s1));
        clk_step();
        check({tag, "_row2"}, 32'(row_o), 32'(s2));
        clk_step();
        min_x = adv_min;
        max_x = adv_max;
        check({tag, "_adv_row"}, 32'(row_o), 32'd0);
        check({tag, "_adv_busy"}, 32'(busy_o), 32'd1);
        clk_step();
        min_x = MID_MIN;
        max_x = MID_MAX;
        check({tag, "_done_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_phase"}, 32'(phase_o), 32'(phase_after));
        exp_phase = phase_after;
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        enable     = 1'b0;
        alive      = 3'b111;
        min_x      = MID_MIN;
        max_x      = MID_MAX;
        exp_phase  = PH_LEFT_A;

        // Reset state.
        clk_step();
        clk_step();
        check("rst_row", 32'(row_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_phase", 32'(phase_o), 32'd0);
        rst = 1'b0;
        clk_step();
        enable = 1'b1;
        clk_step();

        // First sweep: phase flips after the 4th step.
        run_step("step1", 3'b001, 3'b010, 3'b100, MID_MIN, MID_MAX, 2'b00);
        run_step("step2", 3'b001, 3'b010, 3'b100, MID_MIN, MID_MAX, 2'b00);
        run_step("step3", 3'b001, 3'b010, 3'b100, MID_MIN, MID_MAX, 2'b00);
        run_step("step4", 3'b001, 3'b010, 3'b100, MID_MIN, MID_MAX, 2'b01);

        // Three more sweeps walk 01 -> 10 -> 11 -> 00.
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 4; k++) begin
                run_step("sweep", 3'b111 & 3'b001, 3'b010, 3'b100, MID_MIN, MID_MAX,
                         2'(g + 1 + ((k == 3) ? 1 : 0)));
            end
        end

        // Dead middle row still takes its slot.
        alive = 3'b101;
        run_step("mask101", 3'b001, 3'b000, 3'b100, MID_MIN, MID_MAX, 2'b00);
        alive = 3'b111;

        // Edge hits (phase 00 step 1 here).
        run_step("left_hit", 3'b001, 3'b010, 3'b100, 10'd16, MID_MAX, 2'b01);
        run_step("right_hit", 3'b001, 3'b010, 3'b100, MID_MIN, 10'd608, 2'b10);
        run_step("clr_a", 3'b001, 3'b010, 3'b100, MID_MIN, MID_MAX, 2'b10);
        run_step("clr_b", 3'b001, 3'b010, 3'b100, MID_MIN, MID_MAX, 2'b10);
        run_step("clr_c", 3'b001, 3'b010, 3'b100, MID_MIN, MID_MAX, 2'b10);
        run_step("clr_d", 3'b001, 3'b010, 3'b100, MID_MIN, MID_MAX, 2'b11);
        run_step("wrong_side", 3'b001, 3'b010, 3'b100, MID_MIN, 10'd608, 2'b11);
        run_step("left_b_hit", 3'b001, 3'b010, 3'b100, 10'd16, MID_MAX, 2'b00);
        run_step("left_miss17", 3'b001, 3'b010, 3'b100, 10'd17, MID_MAX, 2'b00);

        // Disable during the scan: scan completes, then IDLE (step counter 1 -> 2).
        pulse_tick();
        clk_step();
        pulse_tick();
        check("drop_row0", 32'(row_o), 32'b001);
        enable = 1'b0;
        clk_step();
        check("drop_row1", 32'(row_o), 32'b010);
        clk_step();
        check("drop_row2", 32'(row_o), 32'b100);
        clk_step();
        check("drop_adv_busy", 32'(busy_o), 32'd1);
        clk_step();
        check("drop_idle_busy", 32'(busy_o), 32'd0);
        check("drop_phase", 32'(phase_o), 32'b00);
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            check("idle_tick_row", 32'(row_o), 32'd0);
            check("idle_tick_busy", 32'(busy_o), 32'd0);
        end

        // Tick coinciding with disable in WAIT: disable wins and clears the count.
        enable = 1'b1;
        clk_step();
        pulse_tick();
        check("reen_tick1_busy", 32'(busy_o), 32'd0);
        frame_tick = 1'b1;
        enable     = 1'b0;
        clk_step();
        frame_tick = 1'b0;
        check("tick_vs_dis_busy", 32'(busy_o), 32'd0);
        check("tick_vs_dis_row", 32'(row_o), 32'd0);
        enable = 1'b1;
        clk_step();
        pulse_tick();
        check("reen_first_tick", 32'(busy_o), 32'd0);
        pulse_tick();
        check("reen_row0", 32'(row_o), 32'b001);
        clk_step();
        clk_step();
        clk_step();
        clk_step();
        check("reen_done_busy", 32'(busy_o), 32'd0);
        check("reen_phase", 32'(phase_o), 32'b00);

        // Wave cleared: ticks do nothing and the count holds (step counter is 3).
        alive = 3'b000;
        for (int i = 0; i < 10; i++) begin
            pulse_tick();
            check("dead_row", 32'(row_o), 32'd0);
            check("dead_busy", 32'(busy_o), 32'd0);
            clk_step();
        end
        alive = 3'b111;
        run_step("after_dead", 3'b001, 3'b010, 3'b100, MID_MIN, MID_MAX, 2'b01);

        // Reset in the middle of a scan.
        pulse_tick();
        clk_step();
        pulse_tick();
        check("rst_mid_row0", 32'(row_o), 32'b001);
        rst = 1'b1;
        clk_step();
        check("rst_mid_row", 32'(row_o), 32'd0);
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        check("rst_mid_phase", 32'(phase_o), 32'b00);
        clk_step();
        check("rst_hold_row", 32'(row_o), 32'd0);
        rst = 1'b0;
        clk_step();
        clk_step();
        check("post_rst_row", 32'(row_o), 32'd0);
        check("post_rst_busy", 32'(busy_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
